change_dispenser: RTL and testbench



---
 rtl/change_dispenser_if.sv | 41 ++++
 rtl/change_dispenser.sv | 261 ++++++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// ============================================================================
// change_dispenser_if
// ----------------------------------------------------------------------------
// Purpose : groups the request handshake, coin-mechanism handshake and the
//           status outputs of change_dispenser into one bundle.
// Params  : INV_W - width of the inventory count signals (must match the
//                   INV_W of the change_dispenser instance using it).
// Signals : req_valid/req_ready/req_amt/refill - change request side
//           eject50/eject100/eject_ack          - coin mechanism side
//           done/short/owed                     - request completion status
//           inv50/inv100/jam                    - inventory and fault status
// Modports: master - requester/mechanism side (testbench or host logic)
//           slave  - the dispenser itself
// ============================================================================
interface change_dispenser_if #(
    parameter int INV_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_amt;
    logic             refill;
    logic             eject50;
    logic             eject100;
    logic             eject_ack;
    logic             done;
    logic             short;
    logic [2:0]       owed;
    logic [INV_W-1:0] inv50;
    logic [INV_W-1:0] inv100;
    logic             jam;

    modport master (
        output req_valid, req_amt, refill, eject_ack,
        input  req_ready, eject50, eject100, done, short, owed, inv50, inv100, jam
    );

    modport slave (
        input  req_valid, req_amt, refill, eject_ack,
        output req_ready, eject50, eject100, done, short, owed, inv50, inv100, jam
    );
endinterface

// File: rtl/change_dispenser.sv
// ============================================================================
// change_dispenser
// ----------------------------------------------------------------------------
// Purpose : pays out change (in 50-centavo units) with 100 and 50 coins using
//           greedy largest-coin-first selection. Each coin is a timed eject
//           pulse followed by an acknowledge from the coin mechanism. Tracks
//           coin inventory and reports any unpaid remainder.
//
// Optional feature macro: CHANGE_TIMEOUT_EN
//   defined   - a coin not acknowledged within TIMEOUT_CYC cycles is treated
//               as jammed: its denomination's inventory is zeroed, jam is set
//               (sticky until refill/reset) and payout continues with the
//               other denomination.
//   undefined - the ack wait is unbounded and jam is tied low.
//
// Ports   : CLOCK_50  - clock
//           reset_n   - asynchronous active-low reset
//           bus       - change_dispenser_if.slave:
//             req_valid/req_amt in, req_ready out (high iff idle)
//             refill in (honoured only when idle)
//             eject50/eject100 out, eject_ack in
//             done/short/owed out (completion report, owed held)
//             inv50/inv100 out (inventory), jam out (sticky fault)
// ============================================================================
module change_dispenser #(
    parameter int INV_W       = 4,
    parameter int INIT_50     = 8,
    parameter int INIT_100    = 8,
    parameter int EJECT_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    change_dispenser_if.slave  bus
);

    // Eject counter runs EJECT_CYC-1 down to 0.
    localparam int EC_W = (EJECT_CYC > 1) ? $clog2(EJECT_CYC) : 1;

    if (EJECT_CYC < 1) begin : g_bad_eject_cyc
        $error("change_dispenser: EJECT_CYC must be >= 1");
    end
    if (INIT_50 >= (1 << INV_W)) begin : g_bad_init_50
        $error("change_dispenser: INIT_50 does not fit in INV_W bits");
    end
    if (INIT_100 >= (1 << INV_W)) begin : g_bad_init_100
        $error("change_dispenser: INIT_100 does not fit in INV_W bits");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("change_dispenser: TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_rem;
    logic              r_is100;
    logic [EC_W-1:0]   r_ej_cnt;
    logic [INV_W-1:0]  r_inv50;
    logic [INV_W-1:0]  r_inv100;
    logic              r_eject50;
    logic              r_eject100;
    logic              r_done;
    logic              r_short;
    logic [2:0]        r_owed;

    logic              w_pick100;
    logic              w_pick50;
    logic              w_ack_ok;
    logic              w_jam_hit;
    logic              w_to_expired;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and coin selection
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_pick100 = 1'b0;
        w_pick50  = 1'b0;
        w_ack_ok  = 1'b0;
        w_jam_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                // Greedy: a 100 only when at least two units remain; 50s
                // cover whatever the 100s cannot.
                if ((r_rem >= 3'd2) && (r_inv100 != '0)) begin
                    w_pick100 = 1'b1;
                    w_next    = S_EJECT;
                end else if ((r_rem != 3'd0) && (r_inv50 != '0)) begin
                    w_pick50 = 1'b1;
                    w_next   = S_EJECT;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_EJECT: begin
                if (r_ej_cnt == '0) begin
                    w_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (bus.eject_ack) begin
                    w_ack_ok = 1'b1;
                    w_next   = S_SELECT;
                end else if (w_to_expired) begin
                    w_jam_hit = 1'b1;
                    w_next    = S_SELECT;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: remaining amount, inventory, eject pulses, completion
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rem      <= 3'd0;
            r_is100    <= 1'b0;
            r_ej_cnt   <= '0;
            r_inv50    <= INV_W'(INIT_50);
            r_inv100   <= INV_W'(INIT_100);
            r_eject50  <= 1'b0;
            r_eject100 <= 1'b0;
            r_done     <= 1'b0;
            r_short    <= 1'b0;
            r_owed     <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Refill and request may coincide; SELECT then sees the
                    // reloaded counts because both land on this edge.
                    if (bus.refill) begin
                        r_inv50  <= INV_W'(INIT_50);
                        r_inv100 <= INV_W'(INIT_100);
                    end
                    if (bus.req_valid) begin
                        r_rem <= bus.req_amt;
                    end
                end
                S_SELECT: begin
                    if (w_pick100 || w_pick50) begin
                        r_is100    <= w_pick100;
                        r_eject100 <= w_pick100;
                        r_eject50  <= w_pick50;
                        r_ej_cnt   <= EC_W'(EJECT_CYC - 1);
                    end else begin
                        r_done  <= 1'b1;
                        r_owed  <= r_rem;
                        r_short <= (r_rem != 3'd0);
                    end
                end
                S_EJECT: begin
                    if (r_ej_cnt == '0) begin
                        r_eject100 <= 1'b0;
                        r_eject50  <= 1'b0;
                    end else begin
                        r_ej_cnt <= r_ej_cnt - EC_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack_ok) begin
                        if (r_is100) begin
                            r_inv100 <= r_inv100 - INV_W'(1);
                            r_rem    <= r_rem - 3'd2;
                        end else begin
                            r_inv50 <= r_inv50 - INV_W'(1);
                            r_rem   <= r_rem - 3'd1;
                        end
                    end else if (w_jam_hit) begin
                        // A jammed tube is unusable until refilled; the
                        // amount owed is left for the other denomination.
                        if (r_is100) begin
                            r_inv100 <= '0;
                        end else begin
                            r_inv50 <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_jam;

    // ------------------------------------------------------------------
    // Ack timeout and sticky jam flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
            r_jam    <= 1'b0;
        end else begin
            // Counter equals the number of WAIT_ACK cycles already spent.
            if (r_state == S_WAIT_ACK) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if ((r_state == S_IDLE) && bus.refill) begin
                r_jam <= 1'b0;
            end else if (w_jam_hit) begin
                r_jam <= 1'b1;
            end
        end
    end

    assign w_to_expired = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign bus.jam      = r_jam;
`else
    assign w_to_expired = 1'b0;
    assign bus.jam      = 1'b0;
`endif

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.eject50   = r_eject50;
    assign bus.eject100  = r_eject100;
    assign bus.done      = r_done;
    assign bus.short     = r_short;
    assign bus.owed      = r_owed;
    assign bus.inv50     = r_inv50;
    assign bus.inv100    = r_inv100;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam int INV_W       = 4;
    localparam int INIT_50     = 8;
    localparam int INIT_100    = 8;
    localparam int EJECT_CYC   = 4;
    localparam int TIMEOUT_CYC = 20;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    change_dispenser_if #(.INV_W(INV_W)) bus ();

    change_dispenser #(
        .INV_W      (INV_W),
        .INIT_50    (INIT_50),
        .INIT_100   (INIT_100),
        .EJECT_CYC  (EJECT_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLOCK_50(clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic             sh;
        logic [2:0]       owed;
        logic [INV_W-1:0] i50;
        logic [INV_W-1:0] i100;
        logic             jam;
    } res_t;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state and scoreboard queues
    int   m50;
    int   m100;
    logic mjam;
    int   exp_coin[$];
    res_t exp_res[$];

    // Monitor / ack responder controls
    logic mon_en    = 1'b1;
    int   ack_mode  = 1;   // 0 none, 1 auto, 2 auto + ack during eject, 3 ack 50s only
    int   ack_dly   = 2;
    int   ack_cnt   = 0;
    logic ack_pend50 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic void model(input int amt);
        int   rem;
        res_t r;
        rem = amt;
        for (int k = 0; k < 8; k++) begin
            if (rem >= 2 && m100 > 0) begin
                exp_coin.push_back(100);
                m100--;
                rem -= 2;
            end else if (rem >= 1 && m50 > 0) begin
                exp_coin.push_back(50);
                m50--;
                rem -= 1;
            end
        end
        r.sh   = (rem != 0);
        r.owed = 3'(rem);
        r.i50  = INV_W'(m50);
        r.i100 = INV_W'(m100);
        r.jam  = mjam;
        exp_res.push_back(r);
    endfunction

    // Ack responder: acks ack_dly cycles after an eject pulse ends.
    initial begin
        bus.eject_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_mode == 0) begin
                bus.eject_ack = 1'b0;
                ack_cnt = 0;
            end else if (bus.eject50 | bus.eject100) begin
                bus.eject_ack = (ack_mode == 2);
                ack_cnt = ack_dly;
                ack_pend50 = bus.eject50;
            end else if (ack_cnt > 0) begin
                ack_cnt--;
                bus.eject_ack = (ack_cnt == 0) && (ack_mode != 3 || ack_pend50);
            end else begin
                bus.eject_ack = 1'b0;
            end
        end
    end

    // Monitor: checks every eject pulse and every done against the scoreboard.
    int   plen = 0;
    logic prev_ej = 1'b0;
    int   prev_coin = 0;
    int   mon_c;
    res_t mon_r;

    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                plen = 0;
                prev_ej = 1'b0;
            end else begin
                if (bus.eject50 | bus.eject100) begin
                    check("eject_exclusive", 32'(bus.eject50 & bus.eject100), 0);
                    plen++;
                    prev_coin = bus.eject100 ? 100 : 50;
                end else if (prev_ej) begin
                    check("coin_expected", 32'(exp_coin.size() > 0), 1);
                    if (exp_coin.size() > 0) begin
                        mon_c = exp_coin.pop_front();
                        check("coin_value", prev_coin, mon_c);
                    end
                    check("pulse_len", plen, EJECT_CYC);
                    plen = 0;
                end
                prev_ej = bus.eject50 | bus.eject100;
                if (bus.done === 1'b1) begin
                    check("done_expected", 32'(exp_res.size() > 0), 1);
                    if (exp_res.size() > 0) begin
                        mon_r = exp_res.pop_front();
                        check("done_short",  32'(bus.short),  32'(mon_r.sh));
                        check("done_owed",   32'(bus.owed),   32'(mon_r.owed));
                        check("done_inv50",  32'(bus.inv50),  32'(mon_r.i50));
                        check("done_inv100", 32'(bus.inv100), 32'(mon_r.i100));
                        check("done_jam",    32'(bus.jam),    32'(mon_r.jam));
                        check("coins_pending", exp_coin.size(), 0);
                    end
                end
            end
        end
    end

    task automatic do_req(input int amt, input logic rf, input logic use_model);
        check("req_ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.req_amt   = 3'(amt);
        bus.refill    = rf;
        if (rf) begin
            m50  = INIT_50;
            m100 = INIT_100;
            mjam = 1'b0;
        end
        if (use_model) model(amt);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.refill    = 1'b0;
        check("req_ready_busy", 32'(bus.req_ready), 0);
    endtask

    task automatic wait_done(input int budget, output int cyc);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(bus.done), 1);
        cyc = n;
    endtask

    task automatic finish_done();
        check("ready_during_done", 32'(bus.req_ready), 0);
        @(negedge clk);
        check("ready_after_done", 32'(bus.req_ready), 1);
        check("done_one_cycle", 32'(bus.done), 0);
    endtask

    task automatic pay(input int amt, input logic rf, output int cyc);
        do_req(amt, rf, 1'b1);
        wait_done(400, cyc);
        finish_done();
    endtask

    int   cyc;
    int   n;
    res_t jr;

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_amt   = 3'd0;
        bus.refill    = 1'b0;
        m50  = INIT_50;
        m100 = INIT_100;
        mjam = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_inv50",     32'(bus.inv50), INIT_50);
        check("rst_inv100",    32'(bus.inv100), INIT_100);
        check("rst_owed",      32'(bus.owed), 0);
        check("rst_eject50",   32'(bus.eject50), 0);
        check("rst_eject100",  32'(bus.eject100), 0);
        check("rst_done",      32'(bus.done), 0);
        check("rst_short",     32'(bus.short), 0);
        check("rst_jam",       32'(bus.jam), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 3 units: one 100 then one 50, ack two cycles after each pulse
        ack_mode = 1;
        ack_dly  = 2;
        pay(3, 1'b0, cyc);
        check("t1_inv100", 32'(bus.inv100), 7);
        check("t1_inv50",  32'(bus.inv50), 7);

        // Refill on its own
        bus.refill = 1'b1;
        m50  = INIT_50;
        m100 = INIT_100;
        @(negedge clk);
        bus.refill = 1'b0;
        check("refill_inv50",  32'(bus.inv50), INIT_50);
        check("refill_inv100", 32'(bus.inv100), INIT_100);

        // Drain the 100s, then 50s cover a larger amount
        ack_dly = 1;
        pay(6, 1'b0, cyc);
        pay(6, 1'b0, cyc);
        pay(4, 1'b0, cyc);
        check("drain_inv100", 32'(bus.inv100), 0);
        check("drain_inv50",  32'(bus.inv50), 8);
        pay(4, 1'b0, cyc);
        check("only50_inv50", 32'(bus.inv50), 4);
        pay(4, 1'b0, cyc);
        check("empty_inv50", 32'(bus.inv50), 0);

        // Nothing left: no eject, short with owed=5, done right after SELECT
        pay(5, 1'b0, cyc);
        check("empty_done_latency", cyc, 1);
        check("owed_held", 32'(bus.owed), 5);

        // Zero amount with refill in the same cycle
        pay(0, 1'b1, cyc);
        check("zero_done_latency", cyc, 1);
        check("zero_inv50",  32'(bus.inv50), INIT_50);
        check("zero_inv100", 32'(bus.inv100), INIT_100);

        // Acks asserted during EJECT must be ignored
        ack_mode = 2;
        ack_dly  = 2;
        pay(3, 1'b0, cyc);
        check("spam_inv100", 32'(bus.inv100), 7);
        check("spam_inv50",  32'(bus.inv50), 7);

        // Reset during the second cycle of an eject100 pulse
        mon_en = 1'b0;
        do_req(2, 1'b0, 1'b1);
        n = 0;
        while (bus.eject100 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_eject_start", 32'(bus.eject100), 1);
        @(negedge clk);
        check("abort_eject_second", 32'(bus.eject100), 1);
        check("abort_ack_ignored",  32'(bus.inv100), 7);
        reset_n = 1'b0;
        #1;
        check("abort_eject_drop",  32'(bus.eject100), 0);
        check("abort_req_ready",   32'(bus.req_ready), 1);
        check("abort_inv50",       32'(bus.inv50), INIT_50);
        check("abort_inv100",      32'(bus.inv100), INIT_100);
        check("abort_done",        32'(bus.done), 0);
        ack_mode = 0;
        exp_coin.delete();
        exp_res.delete();
        m50  = INIT_50;
        m100 = INIT_100;
        mjam = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mon_en   = 1'b1;
        ack_mode = 1;
        pay(3, 1'b0, cyc);
        check("post_abort_inv100", 32'(bus.inv100), 7);

`ifdef CHANGE_TIMEOUT_EN
        // No ack for the 100 coin: jam, 100s zeroed, two 50s pay the rest
        pay(0, 1'b1, cyc);
        ack_mode = 3;
        do_req(2, 1'b0, 1'b0);
        exp_coin.push_back(100);
        exp_coin.push_back(50);
        exp_coin.push_back(50);
        m50  = INIT_50 - 2;
        m100 = 0;
        mjam = 1'b1;
        jr.sh   = 1'b0;
        jr.owed = 3'd0;
        jr.i50  = INV_W'(m50);
        jr.i100 = INV_W'(0);
        jr.jam  = 1'b1;
        exp_res.push_back(jr);
        wait_done(400, cyc);
        check("jam_flag",   32'(bus.jam), 1);
        check("jam_inv100", 32'(bus.inv100), 0);
        finish_done();
        ack_mode = 1;
        pay(0, 1'b1, cyc);
        check("jam_cleared", 32'(bus.jam), 0);
`endif

        repeat (3) @(negedge clk);
        check("sb_results_drained", exp_res.size(), 0);
        check("sb_coins_drained",   exp_coin.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
